mpu_add_ctrl: RTL
=================

MPU_ADD_CTRL -- requirements
Module: mpu_add_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4: matrix rows.
REQ-002 SHALL have parameter COLS, default 4: matrix columns.
REQ-003 SHALL have parameter REG_AW, default 3: matrix-register address width.
REQ-004 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request add.
- src0_i  in  REG_AW  source matrix register A.
- src1_i  in  REG_AW  source matrix register B.
- dst_i  in  REG_AW  destination matrix register.
- ready_o  out  1  idle, accepts start_i.
- done_o  out  1  one-cycle completion pulse.
- rd_en_o  out  1  element read strobe.
- rd_reg0_o  out  REG_AW  A register address.
- rd_reg1_o  out  REG_AW  B register address.
- rd_idx_o  out  IDX_W  element index; IDX_W = $clog2(ROWS*COLS).
- rd_data0_i  in  32  A element, valid the cycle after rd_en_o.
- rd_data1_i  in  32  B element, valid the cycle after rd_en_o.
- add_valid_o  out  1  operand pair valid to adder.
- add_a_o  out  32  operand A.
- add_b_o  out  32  operand B.
- add_valid_i  in  1  adder result valid; results return in issue order, any latency.
- add_sum_i  in  32  adder result.
- wr_en_o  out  1  element write strobe.
- wr_reg_o  out  REG_AW  destination address.
- wr_idx_o  out  IDX_W  destination element index.
- wr_data_o  out  32  write data.

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; ready_o=1 only in IDLE.
REQ-006 IDLE: start_i=1 SHALL latch src0_i/src1_i/dst_i, clear counters, go to ISSUE next cycle; start_i in other states SHALL be ignored.
REQ-007 ISSUE: each cycle SHALL assert rd_en_o with rd_idx_o = issue count, 0..ROWS*COLS-1 row-major; after index ROWS*COLS-1, go to DRAIN.
REQ-008 add_valid_o SHALL be rd_en_o delayed one cycle; add_a_o/add_b_o = rd_data0_i/rd_data1_i in that cycle.
REQ-009 Each add_valid_i SHALL produce, in the same cycle combinationally, wr_en_o=1, wr_reg_o=latched dst, wr_idx_o=write count, wr_data_o=add_sum_i; write count then increments.
REQ-010 DRAIN SHALL wait until write count reaches ROWS*COLS, then go to DONE; if the last write occurs in ISSUE's final cycle, go directly to DONE.
REQ-011 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-012 add_valid_i in IDLE or DONE SHALL be ignored: no write, no counter change.
REQ-013 dst equal to a source SHALL be allowed: element i is written only after element i is read.
REQ-014 Counters SHALL be IDX_W+1 bits wide so the ROWS*COLS terminal count does not wrap.
REQ-015 Latency: start_i to done_o = ROWS*COLS + adder latency + 2 cycles.

Reset
REQ-016 rst=0 SHALL asynchronously force IDLE, zero counters and latched addresses, and drive every output to 0 except ready_o=1.
REQ-017 Reset mid-operation SHALL abandon the operation without done_o; the first cycle after deassertion SHALL be IDLE.

Configuration
REQ-018 With MPU_ADD_SUB_EN defined:
- Input port op_i (1 bit) SHALL exist and be latched with start_i.
- op_i=1 SHALL invert bit 31 of add_b_o (A-B).
REQ-019 Without MPU_ADD_SUB_EN: op_i SHALL be absent and add_b_o SHALL pass unmodified.

Structure
REQ-020 The state enum type mpu_add_state_t and the float word type SHALL reside in package global_defs.
REQ-021 The FSM and counters SHALL stay in this module; no sub-module; the adder datapath is instantiated by the parent.

Verification
REQ-022 ROWS=COLS=2, 1-cycle adder, A=1.0f, B=2.0f all elements -> four writes of 0x40400000 at idx 0..3, done_o 7 cycles after start.
REQ-023 start_i held high through the run -> exactly one operation; ready_o low until done_o.
REQ-024 Adder latency 3, src0=dst=2 -> reg2 elements = old A+B, writes in idx order, no early overwrite.
REQ-025 rst pulsed low during DRAIN -> outputs zero immediately, no done_o; next start completes normally.
REQ-026 MPU_ADD_SUB_EN, op_i=1, A=3.0f, B=1.0f -> add_b_o=0xBF800000, wr_data_o=0x40000000.
REQ-027 Spurious add_valid_i while IDLE -> no wr_en_o.

Source files
------------

// File: rtl/global_defs.sv
// Shared types for the matrix-unit controllers: the add-controller FSM state
// and the 32-bit IEEE-754 single-precision word carried between blocks.
package global_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mpu_add_state_t;

  typedef logic [31:0] float_word_t;

  localparam int FLOAT_SIGN_BIT = 31;

  // Negate a float by flipping its sign bit; NaN payloads pass through untouched.
  function automatic float_word_t float_negate(input float_word_t w);
    float_word_t r;
    r = w;
    r[FLOAT_SIGN_BIT] = ~w[FLOAT_SIGN_BIT];
    return r;
  endfunction

endpackage

// File: rtl/mpu_add_ctrl.sv
// Element-wise matrix add sequencer: streams A/B elements to an external adder
// and writes sums back in order. Define MPU_ADD_SUB_EN to add op_i (A-B).
module mpu_add_ctrl
  import global_defs::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int REG_AW = 3,
  localparam int IDX_W = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
`ifdef MPU_ADD_SUB_EN
  input  logic              op_i,
`endif
  input  logic [REG_AW-1:0] src0_i,
  input  logic [REG_AW-1:0] src1_i,
  input  logic [REG_AW-1:0] dst_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [REG_AW-1:0] rd_reg0_o,
  output logic [REG_AW-1:0] rd_reg1_o,
  output logic [IDX_W-1:0]  rd_idx_o,
  input  float_word_t       rd_data0_i,
  input  float_word_t       rd_data1_i,
  output logic              add_valid_o,
  output float_word_t       add_a_o,
  output float_word_t       add_b_o,
  input  logic              add_valid_i,
  input  float_word_t       add_sum_i,
  output logic              wr_en_o,
  output logic [REG_AW-1:0] wr_reg_o,
  output logic [IDX_W-1:0]  wr_idx_o,
  output float_word_t       wr_data_o
);

  localparam int NUM_ELEM = ROWS * COLS;
  localparam int CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(NUM_ELEM);

  mpu_add_state_t    state_reg, state_next;
  logic [CNT_W-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [CNT_W-1:0]  wr_cnt_reg, wr_cnt_next;
  logic [REG_AW-1:0] src0_reg, src0_next;
  logic [REG_AW-1:0] src1_reg, src1_next;
  logic [REG_AW-1:0] dst_reg, dst_next;
  logic              add_valid_reg;
  logic              wr_accept;
`ifdef MPU_ADD_SUB_EN
  logic              op_reg, op_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      wr_cnt_reg    <= '0;
      src0_reg      <= '0;
      src1_reg      <= '0;
      dst_reg       <= '0;
      add_valid_reg <= 1'b0;
`ifdef MPU_ADD_SUB_EN
      op_reg        <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      issue_cnt_reg <= issue_cnt_next;
      wr_cnt_reg    <= wr_cnt_next;
      src0_reg      <= src0_next;
      src1_reg      <= src1_next;
      dst_reg       <= dst_next;
      add_valid_reg <= rd_en_o;
`ifdef MPU_ADD_SUB_EN
      op_reg        <= op_next;
`endif
    end
  end

  // Results are only meaningful while an operation is in flight; stray
  // adder strobes outside ISSUE/DRAIN are dropped without touching counters.
  assign wr_accept = add_valid_i && ((state_reg == ISSUE) || (state_reg == DRAIN));

  always_comb begin
    state_next     = state_reg;
    issue_cnt_next = issue_cnt_reg;
    wr_cnt_next    = wr_cnt_reg;
    src0_next      = src0_reg;
    src1_next      = src1_reg;
    dst_next       = dst_reg;
`ifdef MPU_ADD_SUB_EN
    op_next        = op_reg;
`endif
    ready_o        = 1'b0;
    done_o         = 1'b0;
    rd_en_o        = 1'b0;
    rd_idx_o       = '0;
    wr_en_o        = 1'b0;
    wr_reg_o       = '0;
    wr_idx_o       = '0;
    wr_data_o      = '0;

    if (wr_accept) begin
      wr_en_o     = 1'b1;
      wr_reg_o    = dst_reg;
      wr_idx_o    = wr_cnt_reg[IDX_W-1:0];
      wr_data_o   = add_sum_i;
      wr_cnt_next = wr_cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          src0_next      = src0_i;
          src1_next      = src1_i;
          dst_next       = dst_i;
`ifdef MPU_ADD_SUB_EN
          op_next        = op_i;
`endif
          issue_cnt_next = '0;
          wr_cnt_next    = '0;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        rd_en_o        = 1'b1;
        rd_idx_o       = issue_cnt_reg[IDX_W-1:0];
        issue_cnt_next = issue_cnt_reg + CNT_W'(1);
        if (issue_cnt_reg == LAST_IDX) begin
          state_next = (wr_cnt_next == TERM_CNT) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (wr_cnt_next == TERM_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Source addresses stay on the read port between operations; they read as
  // zero after reset because the latches are cleared there.
  assign rd_reg0_o   = src0_reg;
  assign rd_reg1_o   = src1_reg;
  assign add_valid_o = add_valid_reg;
  assign add_a_o     = add_valid_reg ? rd_data0_i : '0;

`ifdef MPU_ADD_SUB_EN
  float_word_t add_b_sel;
  assign add_b_sel = op_reg ? float_negate(rd_data1_i) : rd_data1_i;
  assign add_b_o   = add_valid_reg ? add_b_sel : '0;
`else
  assign add_b_o   = add_valid_reg ? rd_data1_i : '0;
`endif

endmodule
